fft_bitrev_reorder: RTL and testbench

Output-side reorder buffer for the 64-point SDF FFT pipeline. It accepts the bit-reversed-order sample stream leaving the last butterfly stage and re-emits each frame in natural frequency order (X[0] … X[NFFT-1]). It uses a ping-pong pair of NFFT-deep banks so one frame can be written while the previous frame drains. Valid/ready handshakes on both sides let it sit between the final stage and any downstream consumer.

---
 rtl/fft_bitrev_reorder.sv | 156 +++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that turns a bit-reversed FFT output
// stream into natural bin order, with valid/ready on both sides.
// Ports: clk, rst (async, active-low)
//   in_valid/in_ready/in_re/in_im     : bit-reversed sample stream
//   out_valid/out_ready/out_re/out_im : natural-order stream
//   out_index : bin number of out_re/out_im
//   frame_done : high on the handshake of bin NFFT-1
module fft_bitrev_reorder #(
  parameter int NFFT   = 64,
  parameter int DATA_W = 16,
  localparam int AW    = $clog2(NFFT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [AW-1:0]     out_index,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    EMPTY, FILLING, FULL, DRAINING
  } bank_st_t;

  bank_st_t st_q [2];
  bank_st_t st_d [2];

  logic [DATA_W-1:0] mem_re [2*NFFT];
  logic [DATA_W-1:0] mem_im [2*NFFT];

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          rd_bank;
  logic [AW-1:0] ld_cnt;

  logic          wr_en;
  logic          wr_last;
  logic          more;
  logic          adv;
  logic          full0;
  logic          full1;
  logic          st_bank;
  logic          start;
  logic          ld_en;
  logic          ld_bank;
  logic [AW-1:0] ld_addr;
  logic          ld_last;

  function automatic logic [AW-1:0] bitrev(
    input logic [AW-1:0] a
  );
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  always_comb begin
    in_ready = (st_q[wr_bank] == EMPTY) ||
               (st_q[wr_bank] == FILLING);
    wr_en    = in_valid & in_ready;
    wr_last  = (wr_cnt == AW'(NFFT-1));
    more     = (st_q[rd_bank] == DRAINING);
    adv      = !out_valid || out_ready;
    full0    = (st_q[0] == FULL);
    full1    = (st_q[1] == FULL);
    // With both banks full, the one the write
    // pointer returned to was filled first.
    st_bank  = (full0 && full1) ? wr_bank : full1;
    start    = adv && !more && (full0 || full1);
    ld_en    = adv && (more || start);
    ld_bank  = more ? rd_bank : st_bank;
    ld_addr  = more ? ld_cnt : '0;
    ld_last  = more && (ld_cnt == AW'(NFFT-1));
  end

  // A draining bank is released as soon as its
  // last bin is captured in the output register,
  // so refilling it can overlap that final
  // handshake and streaming never stalls.
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    if (wr_en) begin
      st_d[wr_bank] = wr_last ? FULL : FILLING;
    end
    if (start) begin
      st_d[st_bank] = DRAINING;
    end
    if (ld_en && ld_last) begin
      st_d[rd_bank] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + AW'(1);
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[{wr_bank, bitrev(wr_cnt)}] <= in_re;
      mem_im[{wr_bank, bitrev(wr_cnt)}] <= in_im;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_index <= '0;
      rd_bank   <= 1'b0;
      ld_cnt    <= '0;
    end else if (adv) begin
      if (ld_en) begin
        out_valid <= 1'b1;
        out_re    <= mem_re[{ld_bank, ld_addr}];
        out_im    <= mem_im[{ld_bank, ld_addr}];
        out_index <= ld_addr;
        rd_bank   <= ld_bank;
        ld_cnt    <= ld_addr + AW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign frame_done = out_valid & out_ready &
                      (out_index == AW'(NFFT-1));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: directed frames at NFFT=64
// plus a small NFFT=8 instance.
module tb_fft_bitrev_reorder;
  localparam int N  = 64;
  localparam int W  = 16;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_re;
  logic [W-1:0]  out_im;
  logic [AW-1:0] out_index;
  logic          frame_done;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [7:0] s_in_re = '0;
  logic [7:0] s_in_im = '0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b1;
  logic [7:0] s_out_re;
  logic [7:0] s_out_im;
  logic [2:0] s_out_index;
  logic       s_frame_done;

  fft_bitrev_reorder #(.NFFT(N), .DATA_W(W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .frame_done(frame_done)
  );

  fft_bitrev_reorder #(.NFFT(8), .DATA_W(8)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_re(s_in_re), .in_im(s_in_im),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_re(s_out_re), .out_im(s_out_im),
    .out_index(s_out_index), .frame_done(s_frame_done)
  );

  typedef struct {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t exp_q [$];
  int   s_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  bit stream_mode = 1'b0;
  bit seen_v      = 1'b0;
  int gaps        = 0;
  int drops       = 0;
  bit bp_mode     = 1'b0;
  bit saw_block   = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int bitrev(input int k, input int aw);
    int r = 0;
    for (int i = 0; i < aw; i++) begin
      if (k[i]) r |= 1 << (aw - 1 - i);
    end
    return r;
  endfunction

  // main scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (out_valid && out_ready) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          check("out_index", out_index, e.idx);
          check("frame_done", frame_done,
                32'(e.idx == AW'(N-1)));
        end
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
      if (stream_mode) begin
        if (out_valid) seen_v = 1'b1;
        else if (seen_v && exp_q.size() > 0) gaps++;
      end
    end
  end

  // small-instance monitor
  always @(negedge clk) begin
    int v;
    if (rst && s_out_valid && s_out_ready) begin
      check("s_has_entry", 32'(s_q.size() != 0), 1);
      if (s_q.size() != 0) begin
        v = s_q.pop_front();
        check("s_out_re", s_out_re, 32'(v));
        check("s_out_index", s_out_index, 32'(v));
        check("s_frame_done", s_frame_done,
              32'(v == 7));
      end
    end
  end

  // out_ready backpressure pattern 1,0,0,1
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end
    end
  end

  task automatic send(input logic [W-1:0] re,
                      input logic [W-1:0] im);
    int  t;
    logic acc;
    t = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    forever begin
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) begin
        saw_block = 1'b1;
        if (stream_mode) drops++;
      end
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 2000) begin
        $display("FAIL send_timeout: got in_ready 0 expected 1");
        $fatal(1, "input stalled");
      end
    end
  endtask

  task automatic frame(input int base, input int gap,
                       input int nwr, input bit push);
    int v;
    if (push) begin
      for (int n = 0; n < N; n++) begin
        exp_q.push_back('{re: W'(base + n),
                          im: W'(-(base + n)),
                          idx: AW'(n)});
      end
    end
    for (int k = 0; k < nwr; k++) begin
      v = base + bitrev(k, AW);
      send(W'(v), W'(-v));
      if (gap > 0 && k < nwr - 1) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic latency_check(input string tag);
    in_valid = 1'b0;
    check({tag, "_valid_before"}, out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid_after"}, out_valid, 1);
    check({tag, "_index0"}, out_index, 0);
  endtask

  task automatic drain_wait(input string tag);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int order [8];
    order = '{0, 4, 2, 6, 1, 5, 3, 7};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_index", out_index, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // single frame
    frame(0, 0, N, 1'b1);
    latency_check("single");
    drain_wait("single");

    // four back-to-back frames
    stream_mode = 1'b1;
    seen_v = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      frame(f * 100, 0, N, 1'b1);
    end
    in_valid = 1'b0;
    drain_wait("stream");
    stream_mode = 1'b0;
    check("stream_in_ready_drops", drops, 0);
    check("stream_out_gaps", gaps, 0);

    // output backpressure
    saw_block = 1'b0;
    bp_mode = 1'b1;
    frame(1000, 0, N, 1'b1);
    frame(2000, 0, N, 1'b1);
    frame(3000, 0, N, 1'b1);
    in_valid = 1'b0;
    drain_wait("bp");
    bp_mode = 1'b0;
    out_ready = 1'b1;
    check("bp_in_ready_blocked", saw_block, 1);

    // input gaps
    frame(500, 2, N, 1'b1);
    latency_check("gaps");
    drain_wait("gaps");

    // reset after 30 writes
    frame(0, 0, 30, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst1_out_valid", out_valid, 0);
    check("rst1_frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst1_in_ready", in_ready, 1);

    // reset mid-drain
    frame(700, 0, N, 1'b1);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst2_in_ready", in_ready, 1);
    frame(800, 0, N, 1'b1);
    latency_check("post_rst");
    drain_wait("post_rst");

    // NFFT=8 instance
    for (int n = 0; n < 8; n++) s_q.push_back(n);
    for (int k = 0; k < 8; k++) begin
      s_in_valid = 1'b1;
      s_in_re = 8'(order[k]);
      s_in_im = '0;
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    t = 0;
    while (s_q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("s_drained", s_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
